// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared phase constants, count type and rule presets for life cells
package life_pkg;

  localparam int PH_DEAD  = 0;
  localparam int PH_ALIVE = 1;

  typedef logic [3:0] count_t;

  localparam logic [8:0] CONWAY_B       = 9'b0_0000_1000;
  localparam logic [8:0] CONWAY_S       = 9'b0_0000_1100;
  localparam logic [8:0] BRIANS_BRAIN_B = 9'b0_0000_0100;
  localparam logic [8:0] BRIANS_BRAIN_S = 9'b0_0000_0000;

endpackage

// File: rtl/adder_n.sv
// rtl/adder_n.sv - unsigned W-bit adder with carry-out folded into a W+1 bit sum
module adder_n #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/neighbor_popcount8.sv
// rtl/neighbor_popcount8.sv - three-level adder tree counting set bits of an 8-bit vector
module neighbor_popcount8
  import life_pkg::*;
(
  input  logic [7:0] bits_i,
  output count_t     count_o
);

  logic [1:0] sum_l1 [4];
  logic [2:0] sum_l2 [2];

  // Level 1: pairs of single bits
  for (genvar g = 0; g < 4; g++) begin : g_l1
    adder_n #(.W(1)) u_add (
      .a_i   (bits_i[2*g]),
      .b_i   (bits_i[2*g+1]),
      .sum_o (sum_l1[g])
    );
  end

  // Level 2: pairs of 2-bit partial sums
  for (genvar g = 0; g < 2; g++) begin : g_l2
    adder_n #(.W(2)) u_add (
      .a_i   (sum_l1[2*g]),
      .b_i   (sum_l1[2*g+1]),
      .sum_o (sum_l2[g])
    );
  end

  // Level 3: final 3-bit partial sums give the 0..8 total
  adder_n #(.W(3)) u_add_l3 (
    .a_i   (sum_l2[0]),
    .b_i   (sum_l2[1]),
    .sum_o (count_o)
  );

endmodule

// File: rtl/life_cell_gen.sv
// rtl/life_cell_gen.sv - Generations-rule grid cell with refractory phases, age and event pulses
module life_cell_gen
  import life_pkg::*;
#(
  parameter  int NUM_STATES = 2,
  parameter  int AGE_W      = 8,
  localparam int PW         = $clog2(NUM_STATES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic             state_0,
  input  logic [8:0]       rule_birth,
  input  logic [8:0]       rule_survive,
  input  logic [7:0]       neighbors,
  output logic             state_d,
  output logic             state_q,
  output logic [PW-1:0]    phase_q,
  output logic [AGE_W-1:0] age_q,
  output logic             born,
  output logic             died
);

  if (NUM_STATES < 2 || NUM_STATES > 16) begin : g_bad_states
    $error("life_cell_gen: NUM_STATES must be in 2..16");
  end
  if (AGE_W < 1) begin : g_bad_age
    $error("life_cell_gen: AGE_W must be at least 1");
  end

  localparam logic [PW-1:0]    P_DEAD    = PW'(PH_DEAD);
  localparam logic [PW-1:0]    P_ALIVE   = PW'(PH_ALIVE);
  localparam logic [PW-1:0]    P_LAST    = PW'(NUM_STATES - 1);
  // With only two phases a failing ALIVE cell drops straight to DEAD.
  localparam logic [PW-1:0]    P_DYING0  = (NUM_STATES > 2) ? PW'(2) : P_DEAD;
  localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};

  count_t           count;
  logic [PW-1:0]    step_phase;
  logic [AGE_W-1:0] step_age;
  logic             step_born;
  logic             step_died;

  logic [PW-1:0]    phase_d;
  logic [AGE_W-1:0] age_d;
  logic             born_d;
  logic             died_d;
  logic             born_q;
  logic             died_q;

  neighbor_popcount8 u_popcount (
    .bits_i  (neighbors),
    .count_o (count)
  );

  // Next phase/age/events as if this edge were an enabled step, then load/ena arbitration
  always_comb begin
    step_phase = phase_q;
    step_age   = age_q;
    step_born  = 1'b0;
    step_died  = 1'b0;

    if (phase_q == P_DEAD) begin
      if (rule_birth[count]) begin
        step_phase = P_ALIVE;
        step_age   = '0;
        step_born  = 1'b1;
      end
    end else if (phase_q == P_ALIVE) begin
      if (rule_survive[count]) begin
        step_age = (age_q == AGE_MAX) ? AGE_MAX : age_q + AGE_W'(1);
      end else begin
        step_phase = P_DYING0;
        step_age   = '0;
        step_died  = 1'b1;
      end
    end else begin
      // Refractory phases ignore neighbours; out-of-range encodings also fall back to DEAD.
      step_phase = (phase_q >= P_LAST) ? P_DEAD : phase_q + PW'(1);
    end

    state_d = (step_phase == P_ALIVE);

    phase_d = phase_q;
    age_d   = age_q;
    born_d  = 1'b0;
    died_d  = 1'b0;
    if (load) begin
      phase_d = state_0 ? P_ALIVE : P_DEAD;
      age_d   = '0;
    end else if (ena) begin
      phase_d = step_phase;
      age_d   = step_age;
      born_d  = step_born;
      died_d  = step_died;
    end
  end

  // Cell registers; reset clears everything without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= P_DEAD;
      age_q   <= '0;
      born_q  <= 1'b0;
      died_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      age_q   <= age_d;
      born_q  <= born_d;
      died_q  <= died_d;
    end
  end

  assign state_q = (phase_q == P_ALIVE);
  assign born    = born_q;
  assign died    = died_q;

endmodule

// File: tb/tb_life_cell_gen.sv
// tb/tb_life_cell_gen.sv - directed checks of life_cell_gen in three parameterisations
module tb_life_cell_gen;
  import life_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       load;
  logic       state_0;
  logic [7:0] neighbors;

  logic       c_state_d, c_state_q, c_born, c_died;
  logic [0:0] c_phase;
  logic [7:0] c_age;

  logic       b_state_d, b_state_q, b_born, b_died;
  logic [1:0] b_phase;
  logic [7:0] b_age;

  logic       a_state_d, a_state_q, a_born, a_died;
  logic [0:0] a_phase;
  logic [1:0] a_age;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_cell_gen #(.NUM_STATES(2), .AGE_W(8)) u_conway (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
    .rule_birth(CONWAY_B), .rule_survive(CONWAY_S), .neighbors(neighbors),
    .state_d(c_state_d), .state_q(c_state_q), .phase_q(c_phase), .age_q(c_age),
    .born(c_born), .died(c_died)
  );

  life_cell_gen #(.NUM_STATES(3), .AGE_W(8)) u_brain (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
    .rule_birth(BRIANS_BRAIN_B), .rule_survive(BRIANS_BRAIN_S), .neighbors(neighbors),
    .state_d(b_state_d), .state_q(b_state_q), .phase_q(b_phase), .age_q(b_age),
    .born(b_born), .died(b_died)
  );

  life_cell_gen #(.NUM_STATES(2), .AGE_W(2)) u_age2 (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
    .rule_birth(CONWAY_B), .rule_survive(CONWAY_S), .neighbors(neighbors),
    .state_d(a_state_d), .state_q(a_state_q), .phase_q(a_phase), .age_q(a_age),
    .born(a_born), .died(a_died)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_age [5];
    exp_age = '{1, 2, 3, 3, 3};

    rst = 1'b1; ena = 1'b0; load = 1'b0; state_0 = 1'b0; neighbors = 8'h00;
    tick();
    check("rst_state_q", 32'(c_state_q), 0);
    check("rst_phase",   32'(b_phase),   0);
    check("rst_age",     32'(c_age),     0);
    check("rst_born",    32'(c_born),    0);
    check("rst_died",    32'(c_died),    0);
    rst = 1'b0;

    // 1: birth from DEAD with three neighbours
    load = 1'b1; state_0 = 1'b0;
    tick();
    check("t1_loaded_dead", 32'(c_state_q), 0);
    load = 1'b0; ena = 1'b1; neighbors = 8'b0000_0111;
    #1;
    check("t1_state_d", 32'(c_state_d), 1);
    tick();
    check("t1_state_q", 32'(c_state_q), 1);
    check("t1_born",    32'(c_born),    1);
    check("t1_age",     32'(c_age),     0);
    ena = 1'b0;
    tick();
    check("t1_born_drop", 32'(c_born),    0);
    check("t1_hold",      32'(c_state_q), 1);

    // 2: survive on 2 and 3, die on 4
    ena = 1'b1; neighbors = 8'b0000_0011;
    tick();
    check("t2_age1",  32'(c_age),  1);
    check("t2_born0", 32'(c_born), 0);
    neighbors = 8'b0001_0101;
    tick();
    check("t2_age2", 32'(c_age), 2);
    neighbors = 8'b0000_1111;
    tick();
    check("t2_dead",     32'(c_state_q), 0);
    check("t2_died",     32'(c_died),    1);
    check("t2_age_clr",  32'(c_age),     0);
    ena = 1'b0;
    tick();
    check("t2_died_drop", 32'(c_died), 0);

    // 3: Brian's Brain refractory phase blocks rebirth
    load = 1'b1; state_0 = 1'b1;
    tick();
    check("t3_loaded", 32'(b_phase), 1);
    check("t3_load_born", 32'(b_born), 0);
    load = 1'b0; ena = 1'b1; neighbors = 8'b0000_0011;
    tick();
    check("t3_dying",   32'(b_phase),   2);
    check("t3_state_q", 32'(b_state_q), 0);
    check("t3_died",    32'(b_died),    1);
    check("t3_state_d", 32'(b_state_d), 0);
    tick();
    check("t3_dead",    32'(b_phase), 0);
    check("t3_blocked", 32'(b_born),  0);
    check("t3_died0",   32'(b_died),  0);
    tick();
    check("t3_reborn",  32'(b_phase), 1);
    check("t3_born",    32'(b_born),  1);

    // 4: 2-bit age saturates at 3
    ena = 1'b0; load = 1'b1; state_0 = 1'b1;
    tick();
    check("t4_loaded_age", 32'(a_age), 0);
    load = 1'b0; ena = 1'b1; neighbors = 8'b1010_1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_age%0d", i), 32'(a_age), 32'(exp_age[i]));
      check($sformatf("t4_alive%0d", i), 32'(a_state_q), 1);
    end
    check("t4_wide_age", 32'(c_age), 5);

    // 5: ena low holds everything while neighbours change
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      neighbors = 8'(i * 37 + 1);
      tick();
      check($sformatf("t5_state%0d", i), 32'(c_state_q), 1);
      check($sformatf("t5_age%0d", i),   32'(c_age),     5);
      check($sformatf("t5_ev%0d", i),    32'({c_born, c_died}), 0);
    end
    load = 1'b1; ena = 1'b1; state_0 = 1'b1; neighbors = 8'h00;
    tick();
    check("t5_load_alive", 32'(c_state_q), 1);
    check("t5_load_age",   32'(c_age),     0);
    check("t5_load_died",  32'(c_died),    0);
    state_0 = 1'b0; neighbors = 8'b0000_0111;
    tick();
    check("t5_load_dead",  32'(c_state_q), 0);
    check("t5_load_born",  32'(c_born),    0);

    // 6: asynchronous reset mid-run
    state_0 = 1'b1;
    tick();
    load = 1'b0; ena = 1'b1; neighbors = 8'b0000_0111;
    for (int i = 0; i < 5; i++) tick();
    check("t6_age5", 32'(c_age), 5);
    ena = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(c_state_q), 0);
    check("t6_rst_age",   32'(c_age),     0);
    check("t6_rst_phase", 32'(c_phase),   0);
    @(negedge clk);
    rst = 1'b0; ena = 1'b1;
    tick();
    check("t6_born",  32'(c_born),    1);
    check("t6_alive", 32'(c_state_q), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
